// File: rtl/lc3_ctrl_fsm_if.sv
// Control bundle between the LC-3 sequencer (master) and the datapath/SRAM side (slave).
// Carries the IR/BEN decode inputs and every load strobe, bus gate, mux select and SRAM strobe.
interface lc3_ctrl_fsm_if;
    logic       Run;
    logic       Continue;
    logic [3:0] Opcode;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic       Illegal_op;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        output GatePC, GateMDR, GateALU, GateMARMUX,
        output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Illegal_op
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
        input  GatePC, GateMDR, GateALU, GateMARMUX,
        input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
        input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Illegal_op
    );
endinterface

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 instruction sequencer and decode with parametrised SRAM wait states.
// Define LC3_PAUSE_EN to implement opcode 1101 as the PAUSE/Continue handshake.
module lc3_ctrl_fsm #(
    parameter int MEM_CYCLES = 2,
    parameter int CNT_W      = 4
) (
    input logic            Clk,
    input logic            Reset,
    lc3_ctrl_fsm_if.master bus
);

    typedef enum logic [4:0] {
        S_HALTED,
        S_18, S_33, S_35, S_32,
        S_01, S_05, S_09,
        S_00, S_22, S_12,
        S_04, S_21, S_20,
        S_06, S_07, S_02, S_03, S_10, S_11, S_14,
        S_24, S_26, S_25, S_27, S_23, S_16
`ifdef LC3_PAUSE_EN
        , S_PAUSE1, S_PAUSE2
`endif
    } state_e;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(MEM_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(MEM_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bus.Mem_CE = 1'b0;
    assign bus.Mem_UB = 1'b0;
    assign bus.Mem_LB = 1'b0;

    // NOTE: state lives only in this block and uses non-blocking assignments;
    // the reset is synchronous, so it is sampled like any other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_HALTED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = 2'b00;
        bus.DRMUX      = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.ADDR2MUX   = 2'b00;
        bus.ALUK       = 2'b00;
        bus.Mem_OE     = 1'b1;
        bus.Mem_WE     = 1'b1;
        bus.Illegal_op = 1'b0;

        case (state_q)
            S_HALTED: if (bus.Run) state_d = S_18;

            S_18: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                state_d    = S_33;
            end

            // Shared read state: OE held low for MEM_CYCLES, MDR captured on the last one.
            S_33, S_24, S_25: begin
                bus.Mem_OE = 1'b0;
                if (cnt_q == RD_LAST) begin
                    bus.LD_MDR = 1'b1;
                    case (state_q)
                        S_33:    state_d = S_35;
                        S_24:    state_d = S_26;
                        default: state_d = S_27;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_35: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                state_d     = S_32;
            end

            S_32: begin
                bus.LD_BEN = 1'b1;
                case (bus.Opcode)
                    4'b0000: state_d = S_00;
                    4'b0001: state_d = S_01;
                    4'b0010: state_d = S_02;
                    4'b0011: state_d = S_03;
                    4'b0100: state_d = S_04;
                    4'b0101: state_d = S_05;
                    4'b0110: state_d = S_06;
                    4'b0111: state_d = S_07;
                    4'b1001: state_d = S_09;
                    4'b1010: state_d = S_10;
                    4'b1011: state_d = S_11;
                    4'b1100: state_d = S_12;
                    4'b1110: state_d = S_14;
`ifdef LC3_PAUSE_EN
                    4'b1101: state_d = S_PAUSE1;
`endif
                    default: begin
                        bus.Illegal_op = 1'b1;
                        state_d        = S_18;
                    end
                endcase
            end

            S_01, S_05, S_09: begin
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                case (state_q)
                    S_01:    bus.ALUK = 2'b00;
                    S_05:    bus.ALUK = 2'b01;
                    default: bus.ALUK = 2'b10;
                endcase
                if (state_q != S_09) bus.SR2MUX = bus.IR_5;
                state_d = S_18;
            end

            S_00: state_d = bus.BEN ? S_22 : S_18;

            S_22, S_21: begin
                bus.LD_PC    = 1'b1;
                bus.PCMUX    = 2'b01;
                bus.ADDR1MUX = 1'b1;
                bus.ADDR2MUX = (state_q == S_22) ? 2'b01 : 2'b00;
                state_d      = S_18;
            end

            S_12, S_20: begin
                bus.LD_PC    = 1'b1;
                bus.PCMUX    = 2'b01;
                bus.ADDR2MUX = 2'b11;
                state_d      = S_18;
            end

            S_04: begin
                bus.GatePC = 1'b1;
                bus.DRMUX  = 1'b1;
                bus.LD_REG = 1'b1;
                state_d    = bus.IR_11 ? S_21 : S_20;
            end

            S_06, S_07: begin
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                bus.ADDR2MUX   = 2'b10;
                state_d        = (state_q == S_06) ? S_25 : S_23;
            end

            S_02, S_03, S_10, S_11: begin
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = 2'b01;
                case (state_q)
                    S_02:    state_d = S_25;
                    S_03:    state_d = S_23;
                    default: state_d = S_24;
                endcase
            end

            S_14: begin
                bus.GateMARMUX = 1'b1;
                bus.LD_REG     = 1'b1;
                bus.ADDR1MUX   = 1'b1;
                bus.ADDR2MUX   = 2'b01;
                state_d        = S_18;
            end

            // Indirect pointer is now in MDR; LDI (1010) and STI (1011) differ only in bit 0.
            S_26: begin
                bus.GateMDR = 1'b1;
                bus.LD_MAR  = 1'b1;
                state_d     = bus.Opcode[0] ? S_23 : S_25;
            end

            S_27: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                state_d     = S_18;
            end

            S_23: begin
                bus.SR1MUX  = 1'b1;
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                state_d     = S_16;
            end

            // WE low for MEM_CYCLES, then one hold cycle with WE high before the next fetch.
            S_16: begin
                if (cnt_q != WR_LAST) begin
                    bus.Mem_WE = 1'b0;
                    cnt_d      = cnt_q + CNT_W'(1);
                end else begin
                    state_d = S_18;
                end
            end

`ifdef LC3_PAUSE_EN
            S_PAUSE1: begin
                bus.LD_LED = 1'b1;
                if (bus.Continue) state_d = S_PAUSE2;
            end

            S_PAUSE2: if (!bus.Continue) state_d = S_18;
`endif

            default: state_d = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm: one instance with MEM_CYCLES=2, one with MEM_CYCLES=3.
// Each task traces an instruction from F18 to the next F18 and compares cycles against hand-built vectors.
module tb_lc3_ctrl_fsm;

    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic       drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we, illegal_op;
    } ctl_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    lc3_ctrl_fsm_if if2();
    lc3_ctrl_fsm_if if3();

    lc3_ctrl_fsm #(.MEM_CYCLES(2), .CNT_W(4)) dut2 (.Clk(Clk), .Reset(Reset), .bus(if2));
    lc3_ctrl_fsm #(.MEM_CYCLES(3), .CNT_W(4)) dut3 (.Clk(Clk), .Reset(Reset), .bus(if3));

    ctl_t s2, s3;
    assign s2 = {if2.LD_MAR, if2.LD_MDR, if2.LD_IR, if2.LD_BEN, if2.LD_CC, if2.LD_REG, if2.LD_PC, if2.LD_LED,
                 if2.GatePC, if2.GateMDR, if2.GateALU, if2.GateMARMUX, if2.PCMUX, if2.DRMUX, if2.SR1MUX,
                 if2.SR2MUX, if2.ADDR1MUX, if2.ADDR2MUX, if2.ALUK,
                 if2.Mem_CE, if2.Mem_UB, if2.Mem_LB, if2.Mem_OE, if2.Mem_WE, if2.Illegal_op};
    assign s3 = {if3.LD_MAR, if3.LD_MDR, if3.LD_IR, if3.LD_BEN, if3.LD_CC, if3.LD_REG, if3.LD_PC, if3.LD_LED,
                 if3.GatePC, if3.GateMDR, if3.GateALU, if3.GateMARMUX, if3.PCMUX, if3.DRMUX, if3.SR1MUX,
                 if3.SR2MUX, if3.ADDR1MUX, if3.ADDR2MUX, if3.ALUK,
                 if3.Mem_CE, if3.Mem_UB, if3.Mem_LB, if3.Mem_OE, if3.Mem_WE, if3.Illegal_op};

    int   errors = 0;
    int   checks = 0;
    ctl_t tr[64];
    int   ncyc;

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.mem_oe = 1'b1;
        c.mem_we = 1'b1;
        return c;
    endfunction

    function automatic ctl_t cur(input int which);
        return (which == 3) ? s3 : s2;
    endfunction

    function automatic logic is_f18(input ctl_t c);
        return c.gate_pc && c.ld_mar && c.ld_pc;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_f18(input int which);
        int n = 0;
        while (!is_f18(cur(which)) && n < 64) begin
            step();
            n++;
        end
        if (!is_f18(cur(which))) begin
            errors++;
            checks++;
            $display("FAIL wait_f18: dut%0d reached no F18 within 64 cycles", which);
        end
    endtask

    // Records one instruction's control vectors from F18 up to (not including) the next F18.
    task automatic run(input int which);
        ncyc = 0;
        do begin
            tr[ncyc] = cur(which);
            step();
            ncyc++;
        end while (!is_f18(cur(which)) && ncyc < 64);
    endtask

    task automatic test_reset();
        ctl_t e;
        Reset = 1'b1;
        repeat (3) step();
        if (s2 !== idle()) begin errors++; $display("FAIL reset_defaults: got %h expected %h", s2, idle()); end
        checks++;
        Reset = 1'b0;
        step();
        if (s2 !== idle()) begin errors++; $display("FAIL halted_no_run: got %h expected %h", s2, idle()); end
        checks++;
        if2.Run = 1'b1;
        if3.Run = 1'b1;
        step();
        if2.Run = 1'b0;
        if3.Run = 1'b0;
        e = idle(); e.gate_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1;
        if (s2 !== e) begin errors++; $display("FAIL f18_after_run: got %h expected %h", s2, e); end
        checks++;
        step();
        e = idle(); e.mem_oe = 1'b0;
        if (s2 !== e) begin errors++; $display("FAIL r33_cycle1: got %h expected %h", s2, e); end
        checks++;
        step();
        e.ld_mdr = 1'b1;
        if (s2 !== e) begin errors++; $display("FAIL r33_cycle2: got %h expected %h", s2, e); end
        checks++;
        step();
        e = idle(); e.gate_mdr = 1'b1; e.ld_ir = 1'b1;
        if (s2 !== e) begin errors++; $display("FAIL f35: got %h expected %h", s2, e); end
        checks++;
    endtask

    task automatic test_alu();
        logic [3:0] op[3]   = '{4'b0001, 4'b0101, 4'b1001};
        logic       ir5[3]  = '{1'b1, 1'b0, 1'b1};
        logic [1:0] aluk[3] = '{2'b00, 2'b01, 2'b10};
        logic       sr2[3]  = '{1'b1, 1'b0, 1'b0};
        ctl_t e;
        for (int i = 0; i < 3; i++) begin
            wait_f18(2);
            if2.Opcode = op[i];
            if2.IR_5   = ir5[i];
            run(2);
            if (ncyc !== 6) begin errors++; $display("FAIL alu_latency op=%b: got %0d expected 6", op[i], ncyc); end
            checks++;
            e = idle(); e.ld_ben = 1'b1;
            if (tr[4] !== e) begin errors++; $display("FAIL d32 op=%b: got %h expected %h", op[i], tr[4], e); end
            checks++;
            e = idle(); e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; e.aluk = aluk[i]; e.sr2mux = sr2[i];
            if (tr[5] !== e) begin errors++; $display("FAIL alu_exec op=%b: got %h expected %h", op[i], tr[5], e); end
            checks++;
        end
    endtask

    task automatic test_br();
        ctl_t e;
        wait_f18(2);
        if2.Opcode = 4'b0000;
        if2.BEN    = 1'b0;
        run(2);
        if (ncyc !== 6) begin errors++; $display("FAIL br_not_taken_latency: got %0d expected 6", ncyc); end
        checks++;
        if (tr[5] !== idle()) begin errors++; $display("FAIL br_s00: got %h expected %h", tr[5], idle()); end
        checks++;
        if2.BEN = 1'b1;
        run(2);
        if (ncyc !== 7) begin errors++; $display("FAIL br_taken_latency: got %0d expected 7", ncyc); end
        checks++;
        e = idle(); e.ld_pc = 1'b1; e.pcmux = 2'b01; e.addr1mux = 1'b1; e.addr2mux = 2'b01;
        if (tr[6] !== e) begin errors++; $display("FAIL br_taken_s22: got %h expected %h", tr[6], e); end
        checks++;
        if2.BEN = 1'b0;
    endtask

    task automatic test_jsr();
        ctl_t e;
        for (int k = 0; k < 2; k++) begin
            wait_f18(2);
            if2.Opcode = 4'b0100;
            if2.IR_11  = (k == 1);
            run(2);
            if (ncyc !== 7) begin errors++; $display("FAIL jsr_latency ir11=%0d: got %0d expected 7", k, ncyc); end
            checks++;
            e = idle(); e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1;
            if (tr[5] !== e) begin errors++; $display("FAIL jsr_r7 ir11=%0d: got %h expected %h", k, tr[5], e); end
            checks++;
            e = idle(); e.ld_pc = 1'b1; e.pcmux = 2'b01;
            e.addr1mux = (k == 1);
            e.addr2mux = (k == 1) ? 2'b00 : 2'b11;
            if (tr[6] !== e) begin errors++; $display("FAIL jsr_pc ir11=%0d: got %h expected %h", k, tr[6], e); end
            checks++;
        end
        if2.IR_11 = 1'b0;
    endtask

    task automatic test_ld_lea();
        ctl_t e;
        wait_f18(2);
        if2.Opcode = 4'b0010;
        run(2);
        if (ncyc !== 9) begin errors++; $display("FAIL ld_latency: got %0d expected 9", ncyc); end
        checks++;
        e = idle(); e.gate_marmux = 1'b1; e.ld_mar = 1'b1; e.addr1mux = 1'b1; e.addr2mux = 2'b01;
        if (tr[5] !== e) begin errors++; $display("FAIL ld_mar: got %h expected %h", tr[5], e); end
        checks++;
        e = idle(); e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        if (tr[8] !== e) begin errors++; $display("FAIL ld_s27: got %h expected %h", tr[8], e); end
        checks++;
        if2.Opcode = 4'b1110;
        run(2);
        if (ncyc !== 6) begin errors++; $display("FAIL lea_latency: got %0d expected 6", ncyc); end
        checks++;
        e = idle(); e.gate_marmux = 1'b1; e.ld_reg = 1'b1; e.addr1mux = 1'b1; e.addr2mux = 2'b01;
        if (tr[5] !== e) begin errors++; $display("FAIL lea_exec: got %h expected %h", tr[5], e); end
        checks++;
    endtask

    task automatic test_ldi();
        ctl_t e;
        logic exp_low, exp_mdr;
        wait_f18(3);
        if3.Opcode = 4'b1010;
        run(3);
        if3.Opcode = 4'b0001;
        if (ncyc !== 15) begin errors++; $display("FAIL ldi_latency: got %0d expected 15", ncyc); end
        checks++;
        for (int i = 0; i < 15; i++) begin
            exp_low = (i >= 1 && i <= 3) || (i >= 7 && i <= 9) || (i >= 11 && i <= 13);
            exp_mdr = (i == 3) || (i == 9) || (i == 13);
            if (tr[i].mem_oe !== !exp_low || tr[i].ld_mdr !== exp_mdr) begin
                errors++;
                $display("FAIL ldi_read_window[%0d]: got oe=%b ld_mdr=%b expected oe=%b ld_mdr=%b",
                         i, tr[i].mem_oe, tr[i].ld_mdr, !exp_low, exp_mdr);
            end
            checks++;
        end
        e = idle(); e.gate_mdr = 1'b1; e.ld_mar = 1'b1;
        if (tr[10] !== e) begin errors++; $display("FAIL ldi_s26: got %h expected %h", tr[10], e); end
        checks++;
        e = idle(); e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1;
        if (tr[14] !== e) begin errors++; $display("FAIL ldi_s27: got %h expected %h", tr[14], e); end
        checks++;
    endtask

    task automatic test_illegal();
        logic [3:0] op[3] = '{4'b1111, 4'b1000, 4'b1101};
        ctl_t e;
        for (int i = 0; i < 3; i++) begin
            wait_f18(2);
            if2.Opcode = op[i];
            run(2);
            if (ncyc !== 5) begin errors++; $display("FAIL illegal_latency op=%b: got %0d expected 5", op[i], ncyc); end
            checks++;
            e = idle(); e.ld_ben = 1'b1; e.illegal_op = 1'b1;
            if (tr[4] !== e) begin errors++; $display("FAIL illegal_d32 op=%b: got %h expected %h", op[i], tr[4], e); end
            checks++;
            if (s2.illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_pulse op=%b: got %b expected 0", op[i], s2.illegal_op); end
            checks++;
        end
    endtask

    task automatic test_store();
        ctl_t e;
        logic overlap = 1'b0;
        wait_f18(2);
        if2.Opcode = 4'b0111;
        run(2);
        if (ncyc !== 10) begin errors++; $display("FAIL str_latency: got %0d expected 10", ncyc); end
        checks++;
        e = idle(); e.gate_marmux = 1'b1; e.ld_mar = 1'b1; e.addr2mux = 2'b10;
        if (tr[5] !== e) begin errors++; $display("FAIL str_mar: got %h expected %h", tr[5], e); end
        checks++;
        e = idle(); e.sr1mux = 1'b1; e.aluk = 2'b11; e.gate_alu = 1'b1; e.ld_mdr = 1'b1;
        if (tr[6] !== e) begin errors++; $display("FAIL str_s23: got %h expected %h", tr[6], e); end
        checks++;
        e = idle(); e.mem_we = 1'b0;
        if (tr[7] !== e || tr[8] !== e || tr[9] !== idle()) begin
            errors++;
            $display("FAIL str_write_window: got %h %h %h expected %h %h %h", tr[7], tr[8], tr[9], e, e, idle());
        end
        checks++;
        for (int i = 0; i < ncyc; i++) if (!tr[i].mem_oe && !tr[i].mem_we) overlap = 1'b1;
        if (overlap !== 1'b0) begin errors++; $display("FAIL str_oe_we_overlap: got %b expected 0", overlap); end
        checks++;
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        wait_f18(2);
        if2.Opcode = 4'b0111;
        while (s2.mem_we !== 1'b0 && n < 64) begin
            step();
            n++;
        end
        if (s2.mem_we !== 1'b0) begin errors++; $display("FAIL abort_reach_write: got we=%b expected 0", s2.mem_we); end
        checks++;
        Reset = 1'b1;
        step();
        if (s2 !== idle()) begin errors++; $display("FAIL abort_outputs: got %h expected %h", s2, idle()); end
        checks++;
        if (dut2.cnt_q !== 4'd0) begin errors++; $display("FAIL abort_counter: got %0d expected 0", dut2.cnt_q); end
        checks++;
        Reset = 1'b0;
        repeat (2) step();
        if (s2 !== idle()) begin errors++; $display("FAIL abort_stays_halted: got %h expected %h", s2, idle()); end
        checks++;
    endtask

    initial begin
        Reset = 1'b1;
        if2.Run = 1'b0; if2.Continue = 1'b0; if2.Opcode = 4'b0001; if2.IR_5 = 1'b0; if2.IR_11 = 1'b0; if2.BEN = 1'b0;
        if3.Run = 1'b0; if3.Continue = 1'b0; if3.Opcode = 4'b0001; if3.IR_5 = 1'b0; if3.IR_11 = 1'b0; if3.BEN = 1'b0;
        test_reset();
        test_alu();
        test_br();
        test_jsr();
        test_ld_lea();
        test_ldi();
        test_illegal();
        test_store();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
